// File: rtl/alu_acc_seq.sv
// alu_acc_seq: registered ALU with accumulator and start/done handshake.
// Optional shift-add multiply on op 111 when ALU_ACC_MUL_EN is defined.
`default_nettype none

module alu_acc_seq #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         zero,
    output logic         neg,
    output logic         ovf,
    output logic         err
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic [W-1:0] result_q, result_d, result_hi_q, result_hi_d, acc_q, acc_d;
    logic         carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic         ovf_q, ovf_d, err_q, err_d;
    logic         legal;

    logic [W:0]   add_w, sub_w, accadd_w;

    assign add_w    = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
    assign accadd_w = {1'b0, acc_q} + {1'b0, a_q};

`ifdef ALU_ACC_MUL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mhi_q, mhi_d, mlo_q, mlo_d;
    logic [W:0]       mstep_w;

    // One shift-add step: partial product in mhi, multiplier bits consumed from mlo.
    assign mstep_w = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        legal       = 1'b1;
`ifdef ALU_ACC_MUL_EN
        cnt_d       = cnt_q;
        mhi_d       = mhi_q;
        mlo_d       = mlo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = EXEC;
`ifdef ALU_ACC_MUL_EN
                    if (op == 3'b111) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        mhi_d   = '0;
                        mlo_d   = b;
                    end
`endif
                end
            end
            MUL: begin
`ifdef ALU_ACC_MUL_EN
                mhi_d = mstep_w[W:1];
                mlo_d = {mstep_w[0], mlo_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = EXEC;
                end
`else
                state_d = IDLE;
`endif
            end
            EXEC: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                err_d       = 1'b0;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                result_hi_d = '0;
                case (op_q)
                    3'b000: begin
                        result_d = add_w[W-1:0];
                        carry_d  = add_w[W];
                        ovf_d    = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
                    end
                    3'b001: begin
                        acc_d    = a_q;
                        result_d = a_q;
                    end
                    3'b010: begin
                        result_d = sub_w[W-1:0];
                        carry_d  = sub_w[W];
                        ovf_d    = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
                    end
                    3'b011: begin
                        acc_d    = b_q;
                        result_d = b_q;
                    end
                    3'b100: begin
                        acc_d    = accadd_w[W-1:0];
                        result_d = accadd_w[W-1:0];
                        carry_d  = accadd_w[W];
                        ovf_d    = (acc_q[W-1] == a_q[W-1]) && (accadd_w[W-1] != acc_q[W-1]);
                    end
                    3'b101: result_d = a_q & b_q;
                    3'b110: result_d = a_q ^ b_q;
                    default: begin
`ifdef ALU_ACC_MUL_EN
                        result_d    = mlo_q;
                        result_hi_d = mhi_q;
                        ovf_d       = |mhi_q;
`else
                        // Illegal op: flag it and leave every other output as it was.
                        legal       = 1'b0;
                        err_d       = 1'b1;
                        carry_d     = carry_q;
                        ovf_d       = ovf_q;
                        result_hi_d = result_hi_q;
`endif
                    end
                endcase
                if (legal) begin
                    zero_d = (result_d == '0);
                    neg_d  = result_d[W-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_ACC_MUL_EN
            cnt_q       <= '0;
            mhi_q       <= '0;
            mlo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
`ifdef ALU_ACC_MUL_EN
            cnt_q       <= cnt_d;
            mhi_q       <= mhi_d;
            mlo_q       <= mlo_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: directed, table-driven checks for alu_acc_seq (W=8).
`default_nettype none

module tb_alu_acc_seq;

    localparam logic [2:0] OP_ADD = 3'b000, OP_LDA = 3'b001, OP_SUB = 3'b010,
                           OP_LDB = 3'b011, OP_ACC = 3'b100, OP_AND = 3'b101,
                           OP_XOR = 3'b110, OP_MUL = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       busy, done, carry, zero, neg, ovf, err;
    logic [7:0] result, result_hi, acc;

    int checks = 0;
    int failures = 0;

    alu_acc_seq #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .acc(acc), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a, b, res, hi, acc;
        logic       c, z, n, v, e;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] o, input logic [7:0] x, y, r, h, ac,
                                input logic c, z, n, v, e);
        vec_t t;
        t = {o, x, y, r, h, ac, c, z, n, v, e};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Issue one op from idle; returns the number of edges from acceptance to done.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [63:0] outs();
        return {35'd0, result, result_hi, acc, carry, zero, neg, ovf, err};
    endfunction

    function automatic logic [63:0] expv(input vec_t t);
        return {35'd0, t.res, t.hi, t.acc, t.c, t.z, t.n, t.v, t.e};
    endfunction

    vec_t tbl[17];
    int   lat, ndone;

    initial begin
        tbl[0]  = mk(OP_ADD, 8'h05, 8'h03, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        tbl[2]  = mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        tbl[3]  = mk(OP_SUB, 8'h03, 8'h05, 8'hFE, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        tbl[4]  = mk(OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 8'h00, 0, 0, 0, 1, 0);
        tbl[5]  = mk(OP_LDA, 8'h10, 8'h33, 8'h10, 8'h00, 8'h10, 0, 0, 0, 0, 0);
        tbl[6]  = mk(OP_ACC, 8'h20, 8'h00, 8'h30, 8'h00, 8'h30, 0, 0, 0, 0, 0);
        tbl[7]  = mk(OP_ACC, 8'h20, 8'h00, 8'h50, 8'h00, 8'h50, 0, 0, 0, 0, 0);
        tbl[8]  = mk(OP_ACC, 8'h20, 8'h00, 8'h70, 8'h00, 8'h70, 0, 0, 0, 0, 0);
        tbl[9]  = mk(OP_LDB, 8'h11, 8'hAA, 8'hAA, 8'h00, 8'hAA, 0, 0, 1, 0, 0);
        tbl[10] = mk(OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'hAA, 0, 0, 0, 0, 0);
        tbl[11] = mk(OP_XOR, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hAA, 0, 1, 0, 0, 0);
        tbl[12] = mk(OP_ACC, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        tbl[13] = mk(OP_LDA, 8'h70, 8'h00, 8'h70, 8'h00, 8'h70, 0, 0, 0, 0, 0);
        tbl[14] = mk(OP_ACC, 8'h10, 8'h00, 8'h80, 8'h00, 8'h80, 0, 0, 1, 1, 0);
        tbl[15] = mk(OP_SUB, 8'h05, 8'h05, 8'h00, 8'h00, 8'h80, 0, 1, 0, 0, 0);
        tbl[16] = mk(OP_XOR, 8'h12, 8'h34, 8'h26, 8'h00, 8'h80, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {50'd0, busy, done, outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            chk($sformatf("vec%0d_outputs", i), outs(), expv(tbl[i]));
        end

`ifdef ALU_ACC_MUL_EN
        issue(OP_MUL, 8'hFF, 8'hFF, lat);
        chk("mul_ff_latency", 64'(lat), 64'd9);
        chk("mul_ff_outputs", outs(),
            expv(mk(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h80, 0, 0, 0, 1, 0)));
        issue(OP_MUL, 8'h03, 8'h05, lat);
        chk("mul_small_outputs", outs(),
            expv(mk(OP_MUL, 8'h03, 8'h05, 8'h0F, 8'h00, 8'h80, 0, 0, 0, 0, 0)));
        issue(OP_ADD, 8'h01, 8'h01, lat);
        chk("after_mul_hi_cleared", outs(),
            expv(mk(OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 8'h80, 0, 0, 0, 0, 0)));
`else
        issue(OP_MUL, 8'h44, 8'h55, lat);
        chk("illegal_latency", 64'(lat), 64'd1);
        chk("illegal_outputs", outs(),
            expv(mk(OP_MUL, 8'h44, 8'h55, 8'h26, 8'h00, 8'h80, 0, 0, 0, 0, 1)));
        issue(OP_ADD, 8'h01, 8'h01, lat);
        chk("err_cleared", outs(),
            expv(mk(OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 8'h80, 0, 0, 0, 0, 0)));
`endif

        // start held for 6 edges: accept on every other edge
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h02;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("held_start_done_count", 64'(ndone), 64'd3);

        // start re-asserted while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        op = OP_SUB; a = 8'h09; b = 8'h01;
        ndone = 0;
        @(posedge clk); #1;
        if (done) ndone++;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("busy_start_done_count", 64'(ndone), 64'd1);
        chk("busy_start_result", 64'(result), 64'h02);

        // Reset right after acceptance discards the op
        @(negedge clk);
        start = 1'b1; op = OP_LDA; a = 8'h5A; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", {50'd0, busy, done, outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midop_reset_no_done", 64'(ndone), 64'd0);

`ifdef ALU_ACC_MUL_EN
        issue(OP_LDA, 8'h33, 8'h00, lat);
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mul_busy_midway", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mul_reset_outputs", {50'd0, busy, done, outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mul_reset_no_done", 64'(ndone), 64'd0);
`endif

        issue(OP_ADD, 8'h05, 8'h03, lat);
        chk("post_reset_latency", 64'(lat), 64'd1);
        chk("post_reset_add", outs(),
            expv(mk(OP_ADD, 8'h05, 8'h03, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
